add_pipe_ahead: RTL
===================

ADD_PIPE_AHEAD -- requirements
Module: add_pipe_ahead

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width; multiple of 4*STAGE_NUM.
REQ-002 SHALL have parameter STAGE_NUM, default 4: pipeline stages; range 1..DATA_WIDTH/4.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_flush  input  1  synchronous clear of all in-flight operations.
REQ-006 SHALL have port i_valid  input  1  operand beat offered.
REQ-007 SHALL have port o_ready  output  1  block accepts beat this cycle.
REQ-008 SHALL have port i_num_a  input  DATA_WIDTH  operand a.
REQ-009 SHALL have port i_num_b  input  DATA_WIDTH  operand b.
REQ-010 SHALL have port i_cry  input  1  carry-in (add mode only).
REQ-011 SHALL have port i_sub  input  1  0 = a+b+i_cry, 1 = a-b.
REQ-012 SHALL have port o_valid  output  1  result beat offered.
REQ-013 SHALL have port i_ready  input  1  downstream accepts result.
REQ-014 SHALL have port o_res  output  DATA_WIDTH  sum/difference modulo 2^DATA_WIDTH.
REQ-015 SHALL have port o_cry  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-016 SHALL have port o_ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Beat accepted on cycle where i_valid && o_ready; result offered on cycle where o_valid && i_ready.
REQ-018 Sub mode SHALL use ~i_num_b with carry-in 1; i_cry ignored when i_sub=1.
REQ-019 Slice width SW = DATA_WIDTH/STAGE_NUM; stage k SHALL compute bits [k*SW +: SW] from registered carry of stage k-1, using 4-bit generate/propagate lookahead groups chained within the slice.
REQ-020 Operand bits for stages not yet computed SHALL travel registered alongside the beat; completed result bits likewise (skew/deskew inside block, none visible at ports).
REQ-021 Latency, unstalled: accepted on cycle t -> o_valid with that result on cycle t+STAGE_NUM.
REQ-022 Throughput one beat per cycle while i_ready=1.
REQ-023 Each stage holds a valid bit; stage advances when next stage is empty or advancing (bubble-collapsing); last stage advances on i_ready.
REQ-024 o_ready SHALL equal !stage0_valid || stage0_advances; combinational from i_ready permitted.
REQ-025 While o_valid && !i_ready, o_res/o_cry/o_ovf SHALL stay stable; no beat dropped, duplicated or reordered.
REQ-026 o_ovf = carry into MSB XOR carry out of MSB.
REQ-027 i_flush SHALL clear all stage valid bits next cycle; input beat in same cycle is discarded; o_ready=0 during flush cycle.
REQ-028 Data registers SHALL load only on advance; data of invalid stages is don't-care at ports but o_res SHALL be forced to 0 when o_valid=0.

Reset
REQ-029 Reset assertion SHALL asynchronously clear all valid bits, o_valid=0, o_res=0, o_cry=0, o_ovf=0.
REQ-030 Reset mid-operation SHALL discard in-flight beats; o_ready=1 on first cycle after deassertion.

Structure
REQ-031 Package add_pipe_pkg SHALL hold GRP_WIDTH=4, default DATA_WIDTH/STAGE_NUM constants and the stage payload struct typedef (valid, a, b, res, cry, sub).
REQ-032 One sub-module add_pipe_slice SHALL implement the SW-bit combinational lookahead slice (inputs a, b, cry; outputs res, cry, cry-into-MSB); instantiated STAGE_NUM times.
REQ-033 Elaboration SHALL fail when DATA_WIDTH % (4*STAGE_NUM) != 0.

Verification (DATA_WIDTH=32, STAGE_NUM=4)
REQ-034 Add 0xFFFFFFFF+0x00000001, i_cry=0 -> o_res=0x00000000, o_cry=1, o_ovf=0, o_valid exactly 4 cycles after accept.
REQ-035 Sub 0x80000000-0x00000001 -> o_res=0x7FFFFFFF, o_cry=1, o_ovf=1; add 0x7FFFFFFF+0x1 -> 0x80000000, o_ovf=1.
REQ-036 100 back-to-back random beats, i_ready=1 -> 100 results in order, one per cycle, match reference model.
REQ-037 i_ready=0 for 10 cycles under continuous input -> o_ready drops after 4 beats buffered, held output stable, no loss on release.
REQ-038 i_flush and, separately, i_rst_n low with 3 beats in flight -> no o_valid for those beats; next accepted beat 0x5+0x3 -> 0x8 after 4 cycles.

Source files
------------

// File: rtl/add_pipe_pkg.sv
// Shared constants and stage payload for the pipelined carry-lookahead adder.
package add_pipe_pkg;
  localparam int GRP_WIDTH      = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_STAGE_NUM  = 4;
  localparam int DEF_SW         = DEF_DATA_WIDTH / DEF_STAGE_NUM;
  localparam int MAX_DATA_WIDTH = 256;

  // Sized for the widest supported adder; narrower instances leave the top bits at 0.
  typedef struct packed {
    logic                      valid;
    logic [MAX_DATA_WIDTH-1:0] a;
    logic [MAX_DATA_WIDTH-1:0] b;
    logic [MAX_DATA_WIDTH-1:0] res;
    logic                      cry;
    logic                      sub;
  } stage_t;
endpackage

// File: rtl/add_pipe_slice.sv
// SW-bit combinational adder slice: 4-bit lookahead groups, group carries chained.
module add_pipe_slice
  import add_pipe_pkg::*;
#(
  parameter int SW = DEF_SW
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] res,
  output logic          co,
  output logic          cm
);
  localparam int NG = SW / GRP_WIDTH;

  logic [SW-1:0] g, p;
  logic [SW:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic [SW:0] cv;
    logic        t, pp;
    cv    = '0;
    t     = 1'b0;
    pp    = 1'b0;
    cv[0] = ci;
    for (int gi = 0; gi < NG; gi++) begin
      // every carry in the group is a flat sum-of-products of the group carry-in
      for (int j = 0; j < GRP_WIDTH; j++) begin
        t  = g[gi*GRP_WIDTH + j];
        pp = p[gi*GRP_WIDTH + j];
        for (int m = j - 1; m >= 0; m--) begin
          t  = t | (pp & g[gi*GRP_WIDTH + m]);
          pp = pp & p[gi*GRP_WIDTH + m];
        end
        cv[gi*GRP_WIDTH + j + 1] = t | (pp & cv[gi*GRP_WIDTH]);
      end
    end
    c = cv;
  end

  assign res = p ^ c[SW-1:0];
  assign co  = c[SW];
  assign cm  = c[SW-1];
endmodule

// File: rtl/add_pipe_ahead.sv
// Pipelined add/sub: one SW-bit lookahead slice per stage, bubble-collapsing valid/ready.
module add_pipe_ahead
  import add_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STAGE_NUM  = DEF_STAGE_NUM
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  input  logic                  i_sub,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry,
  output logic                  o_ovf
);
  localparam int SW   = DATA_WIDTH / STAGE_NUM;
  localparam int LAST = STAGE_NUM - 1;

  if (DATA_WIDTH % (GRP_WIDTH * STAGE_NUM) != 0)
    $error("add_pipe_ahead: DATA_WIDTH must be a multiple of 4*STAGE_NUM");
  if (STAGE_NUM < 1 || STAGE_NUM > DATA_WIDTH / GRP_WIDTH)
    $error("add_pipe_ahead: STAGE_NUM out of range");
  if (DATA_WIDTH > MAX_DATA_WIDTH)
    $error("add_pipe_ahead: DATA_WIDTH exceeds MAX_DATA_WIDTH");

  logic [STAGE_NUM-1:0]         adv, load, s_co, s_cm;
  logic [STAGE_NUM-1:0][SW-1:0] s_res;
  logic                         accept, ovf_q;

  for (genvar k = 0; k < STAGE_NUM; k++) begin : g_stage
    stage_t                st, nxt;
    logic [DATA_WIDTH-1:0] a_src, b_src, res_src;
    logic                  sub_src, ci_src;
    logic [SW-1:0]         b_eff;
    logic                  unused_st;

    if (k == 0) begin : g_in
      assign a_src   = i_num_a;
      assign b_src   = i_num_b;
      assign sub_src = i_sub;
      assign ci_src  = i_sub | i_cry;
      assign res_src = '0;
      assign load[k] = accept;
    end else begin : g_mid
      assign a_src   = g_stage[k-1].st.a[DATA_WIDTH-1:0];
      assign b_src   = g_stage[k-1].st.b[DATA_WIDTH-1:0];
      assign sub_src = g_stage[k-1].st.sub;
      assign ci_src  = g_stage[k-1].st.cry;
      assign res_src = g_stage[k-1].st.res[DATA_WIDTH-1:0];
      assign load[k] = adv[k-1];
    end

    if (k == LAST) begin : g_adv_out
      assign adv[k] = st.valid && i_ready;
    end else begin : g_adv_mid
      assign adv[k] = st.valid && (!g_stage[k+1].st.valid || adv[k+1]);
    end

    assign b_eff = sub_src ? ~b_src[k*SW +: SW] : b_src[k*SW +: SW];

    add_pipe_slice #(.SW(SW)) u_slice (
      .a   (a_src[k*SW +: SW]),
      .b   (b_eff),
      .ci  (ci_src),
      .res (s_res[k]),
      .co  (s_co[k]),
      .cm  (s_cm[k])
    );

    always_comb begin
      nxt                      = '0;
      nxt.valid                = 1'b1;
      nxt.a[DATA_WIDTH-1:0]    = a_src;
      nxt.b[DATA_WIDTH-1:0]    = b_src;
      nxt.res[DATA_WIDTH-1:0]  = res_src;
      nxt.res[k*SW +: SW]      = s_res[k];
      nxt.cry                  = s_co[k];
      nxt.sub                  = sub_src;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     st       <= '0;
      else if (i_flush) st.valid <= 1'b0;
      else if (load[k]) st       <= nxt;
      else if (adv[k])  st.valid <= 1'b0;
    end

    // operands of already-computed slices and pad bits are carried but never read
    assign unused_st = ^st;
  end

  assign o_ready = !i_flush && (!g_stage[0].st.valid || adv[0]);
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     ovf_q <= 1'b0;
    else if (!i_flush && load[LAST])  ovf_q <= s_cm[LAST] ^ s_co[LAST];
  end

  assign o_valid = g_stage[LAST].st.valid;
  assign o_res   = o_valid ? g_stage[LAST].st.res[DATA_WIDTH-1:0] : '0;
  assign o_cry   = o_valid & g_stage[LAST].st.cry;
  assign o_ovf   = o_valid & ovf_q;
endmodule
